multicycle_control_fsm: RTL

- Multicycle RISC-V control unit that sequences fetch, decode, execute, memory and writeback over several clocks.
- Consumes the opcode from the instruction register and the ALU Zero flag; produces per-cycle datapath enables and mux selects.
- ALU funct decoding stays in the downstream ALU decoder, which takes alu_op.
- Supported instructions: lw, sw, R-type and beq; I-type ALU and jal are added with the optional feature.

---
 rtl/riscv_ctrl_pkg.sv | 57 +++++
 rtl/imm_src_decoder.sv | 24 ++
 rtl/multicycle_control_fsm.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
// Shared definitions for the multicycle RISC-V control unit. It holds:
//   - opcode constants (instr[6:0])
//   - the control FSM state encoding
//   - datapath mux-select, immediate-type and ALU-operation codes
// Optional feature macro: MC_ITYPE_JAL_EN. Its states are always enumerated
// here so that the encoding stays the same in both builds.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8,
    S_EXECUTEI = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  // result_src
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // alu_src_a
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // alu_src_b
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // alu_op
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // imm_src
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_decoder.sv
// imm_src_decoder
// Purely combinational opcode -> immediate-format select. The same mapping
// feeds the immediate-extend unit, so it lives in its own module.
// Ports:
//   i_op       in  [6:0] opcode
//   o_imm_src  out [1:0] 00 I-type/lw, 01 sw, 10 beq, 11 jal, others 00
module imm_src_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  output logic [1:0] o_imm_src
);

  always_comb begin
    o_imm_src = IMM_I;
    case (i_op)
      OP_STORE:  o_imm_src = IMM_S;
      OP_BRANCH: o_imm_src = IMM_B;
      OP_JAL:    o_imm_src = IMM_J;
      default:   o_imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Multicycle RISC-V control unit: sequences fetch, decode, execute, memory
// and writeback, producing per-cycle datapath enables and mux selects.
// Moore FSM; FETCH, MEMREAD and MEMWRITE additionally look at mem_ready and
// BEQ looks at zero.
// Optional feature macro: MC_ITYPE_JAL_EN adds I-type ALU ops and jal.
// Ports:
//   clk, reset_n (sync, active low)
//   op [6:0], zero, mem_ready                         inputs
//   pc_write, adr_src, mem_write, ir_write, reg_write enables / selects
//   result_src, alu_src_a, alu_src_b, imm_src, alu_op [1:0]
//   illegal_instr  one-cycle pulse in DECODE for unsupported op
//   state [STATE_W-1:0]  current FSM state (debug)
// Handshake: mem_ready high in a memory state means the access completes
// at the end of that cycle; the FSM holds in that state until it does.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int STATE_W  = 4,
  parameter bit WAIT_MEM = 1'b1
)(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [6:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         imm_src,
  output logic [1:0]         alu_op,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state
);

  state_t r_state;
  state_t w_next;
  logic   w_mem_ready;

  assign w_mem_ready = WAIT_MEM ? mem_ready : 1'b1;
  assign state       = STATE_W'(r_state);

  imm_src_decoder u_imm_src_decoder (
    .i_op      (op),
    .o_imm_src (imm_src)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next        = S_FETCH;
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    illegal_instr = 1'b0;

    case (r_state)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = w_mem_ready;
        pc_write   = w_mem_ready;
        w_next     = w_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // OldPC + imm: branch target is ready in ALUOut for BEQ.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECUTER;
          OP_BRANCH:         w_next = S_BEQ;
`ifdef MC_ITYPE_JAL_EN
          OP_ITYPE:          w_next = S_EXECUTEI;
          OP_JAL:            w_next = S_JAL;
`endif
          default: begin
            w_next        = S_FETCH;
            illegal_instr = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        w_next    = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        w_next  = w_mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        w_next    = w_mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        pc_write  = zero;
        w_next    = S_FETCH;
      end
`ifdef MC_ITYPE_JAL_EN
      S_EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_JAL: begin
        // PC <- target held in ALUOut, ALUResult = OldPC + 4 goes to ALUOut
        // for the ALUWB register write.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        w_next    = S_ALUWB;
      end
`endif
      default: w_next = S_FETCH;
    endcase

    // While reset is held, present a clean FETCH view with no write enables.
    if (!reset_n) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_write     = 1'b0;
      illegal_instr = 1'b0;
      adr_src       = 1'b0;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_FOUR;
      alu_op        = ALUOP_ADD;
      result_src    = RES_ALURESULT;
    end
  end

endmodule
